// File: rtl/array_sel_hold.sv
// Selects one element of an unpacked array (host index or auto-scan pointer),
// captures it when nonzero and holds it, with a sticky range error and a saturating hold counter.
module array_sel_hold #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_vec [DEPTH-1:0],
    input  logic [SELW-1:0]  sel,
    input  logic             sel_valid,
    input  logic             scan_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  out_idx,
    output logic             out_valid,
    output logic             err_range,
    output logic [CNTW-1:0]  hold_cnt
);

    // One extra bit so DEPTH=2**SELW still compares correctly.
    localparam logic [SELW:0]   DEPTH_X  = (SELW+1)'(DEPTH);
    localparam logic [SELW-1:0] PTR_LAST = SELW'(DEPTH - 1);

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  hold_q, hold_d;

    logic [SELW-1:0]  idx;
    logic             req;
    logic             in_range;
    logic [WIDTH-1:0] elem;

    assign idx      = scan_en ? ptr_q : sel;
    assign req      = scan_en | sel_valid;
    assign in_range = {1'b0, idx} < DEPTH_X;

    // Decoded mux: an out-of-range index matches no entry, so nothing is read past the array.
    always_comb begin
        elem = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == SELW'(i)) elem = in_vec[i];
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        err_d   = err_q;
        hold_d  = hold_q;

        if (scan_en) ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + SELW'(1);

        if (err_clr) err_d = 1'b0;

        if (req) begin
            if (in_range && elem != '0) begin
                data_d  = elem;
                idx_d   = idx;
                valid_d = 1'b1;
                hold_d  = '0;
            end else begin
                if (!in_range) err_d = 1'b1;
                if (hold_q != '1) hold_d = hold_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_valid = valid_q;
    assign err_range = err_q;
    assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_array_sel_hold.sv
// Randomized and directed checks of array_sel_hold against a behavioural model.
module tb_array_sel_hold;

    localparam int WIDTH = 4;
    localparam int DEPTH = 5;
    localparam int SELW  = 3;
    localparam int CNTW  = 3;
    localparam int HMAX  = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] vec [DEPTH-1:0];
    logic [SELW-1:0]  sel;
    logic             sel_valid;
    logic             scan_en;
    logic             err_clr;
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0]  out_idx;
    logic             out_valid;
    logic             err_range;
    logic [CNTW-1:0]  hold_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    int m_ptr, m_data, m_idx, m_valid, m_err, m_hold;

    array_sel_hold #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SELW(SELW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .in_vec(vec), .sel(sel), .sel_valid(sel_valid),
        .scan_en(scan_en), .err_clr(err_clr), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .err_range(err_range), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_data = 0; m_idx = 0; m_valid = 0; m_err = 0; m_hold = 0;
    endtask

    task automatic model_step();
        int i;
        bit req;
        req = scan_en || sel_valid;
        i = scan_en ? m_ptr : int'(sel);
        m_valid = 0;
        if (err_clr) m_err = 0;
        if (req) begin
            if (i < DEPTH && vec[i] != 0) begin
                m_data = vec[i]; m_idx = i; m_valid = 1; m_hold = 0;
            end else begin
                if (i >= DEPTH) m_err = 1;
                m_hold = (m_hold < HMAX) ? m_hold + 1 : HMAX;
            end
        end
        if (scan_en) m_ptr = (m_ptr + 1) % DEPTH;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  32'(out_data),  32'(m_data));
        chk({tag, ".idx"},   32'(out_idx),   32'(m_idx));
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".err"},   32'(err_range), 32'(m_err));
        chk({tag, ".hold"},  32'(hold_cnt),  32'(m_hold));
    endtask

    // Advance one clock edge, update the model from the inputs seen at that edge, check after.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without an edge.
    task automatic rst_pulse(input string tag);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 rst = 1'b0;
    endtask

    task automatic idle();
        sel_valid = 1'b0; scan_en = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        int exp_idx [6] = '{0, 0, 2, 2, 4, 0};
        int exp_vld [6] = '{1, 0, 1, 0, 1, 1};

        rst = 1'b1;
        idle();
        sel = '0;
        for (int i = 0; i < DEPTH; i++) vec[i] = '0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // Host capture of a nonzero element, then an idle cycle.
        vec[2] = 4'hA; sel = 3'd2; sel_valid = 1'b1;
        cyc("cap");
        chk("cap.data_A", 32'(out_data), 32'hA);
        chk("cap.idx_2", 32'(out_idx), 32'd2);
        chk("cap.valid_1", 32'(out_valid), 32'd1);
        idle();
        cyc("cap_idle");
        chk("idle.valid_0", 32'(out_valid), 32'd0);

        // Zero element requested repeatedly: counter climbs and saturates.
        vec[3] = '0; sel = 3'd3; sel_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc("zero");
            chk("zero.hold_sat", 32'(hold_cnt), 32'((k + 1 < HMAX) ? k + 1 : HMAX));
            chk("zero.data_A", 32'(out_data), 32'hA);
        end

        // Range error: sticky, cleared by err_clr, set wins over clear.
        sel = 3'd6; sel_valid = 1'b1;
        cyc("oor");
        chk("oor.err_1", 32'(err_range), 32'd1);
        idle();
        cyc("oor_stay");
        chk("oor.err_stays", 32'(err_range), 32'd1);
        err_clr = 1'b1;
        cyc("clr");
        chk("clr.err_0", 32'(err_range), 32'd0);
        sel = 3'd7; sel_valid = 1'b1; err_clr = 1'b1;
        cyc("clr_set");
        chk("clr_set.err_1", 32'(err_range), 32'd1);
        idle();

        // Auto-scan overrides the host request.
        vec[0] = 4'd5; vec[1] = 4'd0; vec[2] = 4'd3; vec[3] = 4'd0; vec[4] = 4'd1;
        scan_en = 1'b1; sel = 3'd1; sel_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc("scan");
            chk("scan.idx_tbl", 32'(out_idx), 32'(exp_idx[k]));
            chk("scan.vld_tbl", 32'(out_valid), 32'(exp_vld[k]));
        end

        // Reset mid-scan, then scan restarts from index 0.
        vec[0] = 4'd5; sel_valid = 1'b0;
        for (int k = 0; k < 3; k++) cyc("prescan");
        chk("prescan.nonzero", 32'(out_data != 0), 32'd1);
        rst_pulse("midrst");
        chk("midrst.data_0", 32'(out_data), 32'd0);
        cyc("resume");
        chk("resume.idx_0", 32'(out_idx), 32'd0);
        chk("resume.valid_1", 32'(out_valid), 32'd1);
        idle();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < DEPTH; i++)
                    vec[i] = ($urandom_range(0, 2) == 0) ? '0 : WIDTH'($urandom);
            sel       = SELW'($urandom);
            sel_valid = 1'($urandom);
            scan_en   = ($urandom_range(0, 3) == 0);
            err_clr   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) rst_pulse("rnd_rst");
            cyc("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
